// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: frames a byte (start, 7/8 data LSB first, optional
// parity, stop) and paces it out one bit per BTU tick of an external baud timer.
module uart_tx_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  input  logic       eight,
  input  logic       pen,
  input  logic       ohel,
  input  logic       btu,
  output logic       baud_start,
  output logic       tx,
  output logic       tx_rdy
);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e      state_q, state_d;
  logic [10:0] shreg_q, shreg_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  nbits_q, nbits_d;
  logic        bstart_q, bstart_d;
  logic        rdy_q, rdy_d;

  logic        par;
  logic        pslot;
  logic [3:0]  cnt_inc;
  logic [10:0] frame;

  // Parity covers only the data bits actually sent; with parity off the slot
  // is a 1 so it reads as (part of) the stop level.
  assign par     = (^tx_data[6:0]) ^ (eight & tx_data[7]) ^ ohel;
  assign pslot   = pen ? par : 1'b1;
  assign cnt_inc = cnt_q + 4'd1;
  assign frame   = eight ? {1'b1, pslot, tx_data, 1'b0}
                         : {2'b11, pslot, tx_data[6:0], 1'b0};

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    nbits_d  = nbits_q;
    bstart_d = bstart_q;
    rdy_d    = rdy_q;
    case (state_q)
      IDLE: begin
        bstart_d = 1'b0;
        rdy_d    = 1'b1;
        if (tx_load) begin
          shreg_d  = frame;
          nbits_d  = 4'd9 + {3'b000, eight} + {3'b000, pen};
          cnt_d    = 4'd0;
          bstart_d = 1'b1;
          rdy_d    = 1'b0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        bstart_d = 1'b1;
        rdy_d    = 1'b0;
        if (btu) begin
          // Dropping Start for one cycle restarts the timer for the next bit.
          shreg_d  = {1'b1, shreg_q[10:1]};
          cnt_d    = cnt_inc;
          bstart_d = 1'b0;
          if (cnt_inc == nbits_q) begin
            rdy_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      shreg_q  <= '1;
      cnt_q    <= '0;
      nbits_q  <= '0;
      bstart_q <= 1'b0;
      rdy_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      nbits_q  <= nbits_d;
      bstart_q <= bstart_d;
      rdy_q    <= rdy_d;
    end
  end

  // Bits beyond the frame are 1, so once the frame has shifted out the line
  // sits at the idle/stop level.
  assign tx         = shreg_q[0];
  assign tx_rdy     = rdy_q;
  assign baud_start = bstart_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: stub baud timer, frame-level model checked every
// cycle, plus directed frames with hand-computed bit patterns and durations.
module tb_uart_tx_ctrl;
  localparam int C  = 4;
  localparam int BT = C + 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_load = 1'b0;
  logic       eight = 1'b1;
  logic       pen = 1'b0;
  logic       ohel = 1'b0;
  logic       btu;
  logic       btu_force = 1'b0;
  logic       baud_start, tx, tx_rdy;

  int n_tests = 0;
  int n_fail  = 0;
  int tcnt    = 0;

  always #5 clk = ~clk;

  uart_tx_ctrl dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_load(tx_load),
    .eight(eight), .pen(pen), .ohel(ohel), .btu(btu),
    .baud_start(baud_start), .tx(tx), .tx_rdy(tx_rdy)
  );

  // Stub baud timer: clears while Start is low, counts to C and holds there.
  always @(posedge clk) tcnt <= !baud_start ? 0 : ((tcnt == C) ? C : tcnt + 1);
  assign btu = (baud_start && (tcnt == C)) || btu_force;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int frame_len(input logic e, input logic p);
    return 2 + (e ? 8 : 7) + (p ? 1 : 0);
  endfunction

  // Frame as a list of line levels in send order: start, data, parity?, then 1s.
  function automatic logic [10:0] frame_bits(input logic [7:0] d, input logic e,
                                             input logic p, input logic o);
    logic [10:0] f;
    logic        x;
    int          nd;
    f  = '1;
    x  = o;
    nd = e ? 8 : 7;
    f[0] = 1'b0;
    for (int i = 0; i < nd; i++) begin
      f[1+i] = d[i];
      x      = x ^ d[i];
    end
    if (p) f[1+nd] = x;
    return f;
  endfunction

  // Model: which frame bit is on the line, and whether the timer is in its
  // one-cycle restart gap.
  logic        m_busy = 1'b0;
  logic        m_gap  = 1'b0;
  int          m_idx  = 0;
  int          m_n    = 0;
  logic [10:0] m_bits = '1;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy <= 1'b0;
      m_gap  <= 1'b0;
      m_idx  <= 0;
    end else if (!m_busy) begin
      if (tx_load) begin
        m_bits <= frame_bits(tx_data, eight, pen, ohel);
        m_n    <= frame_len(eight, pen);
        m_idx  <= 0;
        m_busy <= 1'b1;
        m_gap  <= 1'b0;
      end
    end else if (btu) begin
      m_idx <= m_idx + 1;
      m_gap <= (m_idx + 1 != m_n);
      if (m_idx + 1 == m_n) m_busy <= 1'b0;
    end else begin
      m_gap <= 1'b0;
    end
  end

  logic chk_en = 1'b0;
  logic e_tx;
  always @(negedge clk) begin
    if (chk_en) begin
      e_tx = m_busy ? m_bits[m_idx] : 1'b1;
      cmp("model_tx", tx, e_tx);
      cmp("model_tx_rdy", tx_rdy, !m_busy);
      cmp("model_baud_start", baud_start, m_busy && !m_gap);
    end
  end

  // Called just after a negedge; returns just after the negedge following the load edge.
  task automatic load_byte(input logic [7:0] d, input logic e, input logic p, input logic o);
    tx_data = d; eight = e; pen = p; ohel = o; tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
  endtask

  // Collects tx each cycle until tx_rdy rises; mode 1 = load attempt during bit 3
  // (spanning its btu edge), mode 2 = config flip mid-frame.
  task automatic capture_check(input string nm, input int n, input logic [10:0] exp_bits,
                               input int exp_dur, input int mode);
    logic q[$];
    logic [10:0] seen;
    int dur;
    dur = 0;
    while (!tx_rdy && dur < 200) begin
      q.push_back(tx);
      if (mode == 1 && dur == 3*BT - 1) begin tx_data = 8'hFF; tx_load = 1'b1; end
      if (mode == 1 && dur == 4*BT - 1) tx_load = 1'b0;
      if (mode == 2 && dur == 10) begin eight = ~eight; pen = ~pen; ohel = ~ohel; end
      dur++;
      @(negedge clk);
    end
    tx_load = 1'b0;
    seen = '0;
    for (int k = 0; k < n; k++)
      if (k*BT + 1 < q.size()) seen[k] = q[k*BT + 1];
    cmp({nm, "_bits"}, seen, exp_bits);
    // The start bit has no restart gap ahead of it, so it is one cycle short.
    cmp({nm, "_cycles"}, dur, exp_dur);
  endtask

  initial begin
    int lows;
    repeat (3) @(negedge clk);
    cmp("reset_tx", tx, 1);
    cmp("reset_tx_rdy", tx_rdy, 1);
    cmp("reset_baud_start", baud_start, 0);
    reset = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);

    btu_force = 1'b1;
    repeat (3) @(negedge clk);
    btu_force = 1'b0;
    cmp("idle_btu_tx", tx, 1);
    cmp("idle_btu_rdy", tx_rdy, 1);

    load_byte(8'h55, 1, 0, 0);
    cmp("load_tx_start", tx, 0);
    cmp("load_baud_start", baud_start, 1);
    cmp("load_tx_rdy", tx_rdy, 0);
    capture_check("f55_8n1", 10, 11'b01010101010, 10*BT - 1, 0);
    repeat (2) @(negedge clk);

    load_byte(8'hA5, 1, 1, 0);
    capture_check("fA5_8e1", 11, 11'b10101001010, 11*BT - 1, 0);
    repeat (2) @(negedge clk);
    load_byte(8'hA5, 1, 1, 1);
    capture_check("fA5_8o1", 11, 11'b11101001010, 11*BT - 1, 0);
    repeat (2) @(negedge clk);

    load_byte(8'hC1, 0, 1, 1);
    capture_check("fC1_7o1", 10, 11'b01110000010, 10*BT - 1, 2);
    repeat (2) @(negedge clk);
    load_byte(8'h7F, 0, 0, 0);
    capture_check("f7F_7n1", 9, 11'b00111111110, 9*BT - 1, 0);
    repeat (2) @(negedge clk);

    load_byte(8'h0F, 1, 0, 0);
    capture_check("f0F_busy", 10, 11'b01000011110, 10*BT - 1, 1);
    lows = 0;
    repeat (20) begin
      if (!tx_rdy) lows++;
      @(negedge clk);
    end
    cmp("busy_no_second_frame", lows, 0);

    load_byte(8'h42, 1, 0, 0);
    capture_check("f42_b2b_first", 10, 11'b01010000100, 10*BT - 1, 0);
    cmp("b2b_gap_baud_start", baud_start, 0);
    load_byte(8'h81, 1, 0, 0);
    cmp("b2b_start_tx", tx, 0);
    cmp("b2b_start_baud_start", baud_start, 1);
    capture_check("f81_b2b_second", 10, 11'b01100000010, 10*BT - 1, 0);
    repeat (2) @(negedge clk);

    load_byte(8'h00, 1, 0, 0);
    repeat (5*BT + 1) @(negedge clk);
    cmp("midrst_pre_tx", tx, 0);
    #2 reset = 1'b1;
    #1;
    cmp("midrst_tx", tx, 1);
    cmp("midrst_tx_rdy", tx_rdy, 1);
    cmp("midrst_baud_start", baud_start, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    load_byte(8'h3C, 1, 0, 0);
    capture_check("f3C_after_rst", 10, 11'b01001111000, 10*BT - 1, 0);
    repeat (3) @(negedge clk);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench still running at %0t, limit 100000", $time);
    $fatal(1, "watchdog");
  end

endmodule
